// File: rtl/sensor_training_pkg.sv
// Shared FSM encoding and training-word constant for the sensor LVDS alignment trainer.
package sensor_training_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_EVAL,
    ST_DONE
  } state_t;

  localparam logic [9:0] TRAIN_PATTERN_DEF = 10'h3A6;

  // Slip counter must hold DATA_W itself, the "out of slips" value.
  function automatic int slip_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/sensor_training_lane.sv
// One channel of word alignment: sticky mismatch, slip counter, lock flag and bitslip pulse.
// Combinational bitslip/fail in the EVAL cycle; no flow control, the trainer paces every step.
module training_lane
  import sensor_training_pkg::*;
#(
  parameter int                DATA_W        = 10,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(TRAIN_PATTERN_DEF),
  parameter int                SLIP_W        = 4
) (
  input  logic              clk_rxg,
  input  logic              rst_rx_n,
  input  logic              clear_i,
  input  logic              check_i,
  input  logic              eval_i,
  input  logic [DATA_W-1:0] word_i,
  output logic              bitslip_o,
  output logic              locked_o,
  output logic              lock_nxt_o,
  output logic              fail_o
);

  logic              mismatch_q, mismatch_d;
  logic              locked_q, locked_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic              slips_left;

  assign slips_left = (slip_cnt_q < SLIP_W'(DATA_W));

  always_comb begin
    bitslip_o  = eval_i & ~locked_q & mismatch_q & slips_left;
    fail_o     = eval_i & ~locked_q & mismatch_q & ~slips_left;
    lock_nxt_o = locked_q | ~mismatch_q;
    locked_o   = locked_q;
  end

  // A locked lane never raises mismatch again, so it cannot slip or fail.
  always_comb begin
    mismatch_d = mismatch_q;
    locked_d   = locked_q;
    slip_cnt_d = slip_cnt_q;
    if (clear_i) begin
      mismatch_d = 1'b0;
      locked_d   = 1'b0;
      slip_cnt_d = '0;
    end else if (eval_i) begin
      mismatch_d = 1'b0;
      if (!mismatch_q) locked_d = 1'b1;
      if (bitslip_o) slip_cnt_d = slip_cnt_q + SLIP_W'(1);
    end else if (check_i && !locked_q && (word_i != TRAIN_PATTERN)) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      mismatch_q <= 1'b0;
      locked_q   <= 1'b0;
      slip_cnt_q <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      locked_q   <= locked_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

endmodule

// File: rtl/sensor_training.sv
// Sensor LVDS word-alignment trainer: settle, check window, evaluate/bitslip until all lanes lock.
// Zero-slip pass in 1+SETTLE_CYC+MATCH_CYC+1 cycles; no backpressure, the start level aborts a run when dropped.
module sensor_training
  import sensor_training_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter int                DATA_W        = 10,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(TRAIN_PATTERN_DEF),
  parameter int                SETTLE_CYC    = 8,
  parameter int                MATCH_CYC     = 16
) (
  input  logic                     clk_rxg,
  input  logic                     rst_rx_n,
  input  logic                     cmd_start_training,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic [NUM_CH-1:0]        bitslip,
  output logic [NUM_CH-1:0]        channel_locked,
  output logic                     training_done,
  output logic                     training_error
);

  localparam int SLIP_W = slip_w(DATA_W);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int WIN_W  = $clog2(MATCH_CYC + 1);

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic               error_q, error_d;
  logic               start_clr, check_en, eval_en;
  logic [NUM_CH-1:0]  lock_nxt, fail;

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_start_training) state_d = ST_SETTLE;
      ST_SETTLE: if (!cmd_start_training) state_d = ST_IDLE;
                 else if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) state_d = ST_CHECK;
      ST_CHECK:  if (!cmd_start_training) state_d = ST_IDLE;
                 else if (win_cnt_q == WIN_W'(MATCH_CYC - 1)) state_d = ST_EVAL;
      ST_EVAL:   if (!cmd_start_training) state_d = ST_IDLE;
                 else if ((&lock_nxt) || (|fail)) state_d = ST_DONE;
                 else state_d = ST_SETTLE;
      ST_DONE:   if (!cmd_start_training) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Lane strobes are gated by the start level so an abort never slips or updates lanes.
  always_comb begin
    start_clr     = (state_q == ST_IDLE) && cmd_start_training;
    check_en      = (state_q == ST_CHECK) && cmd_start_training;
    eval_en       = (state_q == ST_EVAL) && cmd_start_training;
    training_done = (state_q == ST_DONE);
  end

  always_comb begin
    settle_cnt_d = '0;
    win_cnt_d    = '0;
    error_d      = error_q;
    if ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) settle_cnt_d = settle_cnt_q + SET_W'(1);
    if ((state_q == ST_CHECK) && (state_d == ST_CHECK))   win_cnt_d    = win_cnt_q + WIN_W'(1);
    if (start_clr)                 error_d = 1'b0;
    else if (eval_en && (|fail))   error_d = 1'b1;
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      error_q      <= 1'b0;
    end else begin
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      error_q      <= error_d;
    end
  end

  assign training_error = error_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    training_lane #(
      .DATA_W       (DATA_W),
      .TRAIN_PATTERN(TRAIN_PATTERN),
      .SLIP_W       (SLIP_W)
    ) u_lane (
      .clk_rxg   (clk_rxg),
      .rst_rx_n  (rst_rx_n),
      .clear_i   (start_clr),
      .check_i   (check_en),
      .eval_i    (eval_en),
      .word_i    (rx_data[k*DATA_W +: DATA_W]),
      .bitslip_o (bitslip[k]),
      .locked_o  (channel_locked[k]),
      .lock_nxt_o(lock_nxt[k]),
      .fail_o    (fail[k])
    );
  end

endmodule

// File: tb/tb_sensor_training.sv
// Bench for sensor_training: a rotating-sensor model slips on each bitslip pulse; expected slips,
// lock mask, error and done latency come from the training rules (rounds of settle+window+eval).
module tb_sensor_training;

  localparam int NUM_CH = 4;
  localparam int DW     = 10;
  localparam int SETTLE = 8;
  localparam int MATCH  = 16;
  localparam int ROUND  = SETTLE + MATCH + 1;
  localparam logic [DW-1:0] PAT = 10'h3A6;

  logic                 clk_rxg = 1'b0;
  logic                 rst_rx_n;
  logic                 cmd;
  logic [NUM_CH*DW-1:0] rx_data;
  logic [NUM_CH-1:0]    bitslip, channel_locked;
  logic                 training_done, training_error;

  int                   cfg_rot[NUM_CH];
  int                   base[NUM_CH];
  int                   slip_total[NUM_CH];
  logic [NUM_CH-1:0]    stuck, glitch;
  int                   tests_run, tests_failed;

  sensor_training dut (
    .clk_rxg           (clk_rxg),
    .rst_rx_n          (rst_rx_n),
    .cmd_start_training(cmd),
    .rx_data           (rx_data),
    .bitslip           (bitslip),
    .channel_locked    (channel_locked),
    .training_done     (training_done),
    .training_error    (training_error)
  );

  always #5 clk_rxg = ~clk_rxg;

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int n);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[DW-2:0], r[DW-1]};
    return r;
  endfunction

  // Sensor model: each bitslip removes one bit of rotation from the channel's word.
  always_comb begin
    rx_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      rx_data[k*DW +: DW] = stuck[k] ? '0 :
        (rotl(PAT, (cfg_rot[k] + 200 - (slip_total[k] - base[k])) % DW) ^ {{(DW-1){1'b0}}, glitch[k]});
  end

  always @(negedge clk_rxg)
    for (int k = 0; k < NUM_CH; k++)
      if (bitslip[k] === 1'b1) slip_total[k] <= slip_total[k] + 1;

  function automatic int slips(input int k);
    return slip_total[k] - base[k];
  endfunction

  task automatic set_lanes(input int r[NUM_CH], input logic [NUM_CH-1:0] st);
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_rot[k] = r[k];
      base[k]    = slip_total[k];
    end
    stuck = st;
  endtask

  task automatic run_to_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 400) begin
      @(posedge clk_rxg); #1;
      lat++;
      if (training_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_rx_n = 1'b0; cmd = 1'b0;
    repeat (3) @(posedge clk_rxg); #1;
    tests_run++; if (bitslip !== 4'h0) begin tests_failed++; $display("FAIL reset_bitslip: got %h expected 0", bitslip); end
    tests_run++; if (channel_locked !== 4'h0) begin tests_failed++; $display("FAIL reset_locked: got %h expected 0", channel_locked); end
    tests_run++; if (training_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", training_done); end
    tests_run++; if (training_error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b expected 0", training_error); end
    @(negedge clk_rxg) rst_rx_n = 1'b1;
    repeat (4) @(posedge clk_rxg); #1;
    tests_run++; if (training_done !== 1'b0) begin tests_failed++; $display("FAIL idle_done: got %b expected 0", training_done); end
  endtask

  task automatic test_aligned();
    int r[NUM_CH] = '{0, 0, 0, 0};
    int lat; bit ok;
    set_lanes(r, 4'h0);
    @(negedge clk_rxg) cmd = 1'b1;
    run_to_done(lat, ok);
    tests_run++; if (!ok || lat != 1 + ROUND) begin tests_failed++; $display("FAIL aligned_latency: got %0d (done=%b) expected %0d", lat, ok, 1 + ROUND); end
    tests_run++; if (training_error !== 1'b0) begin tests_failed++; $display("FAIL aligned_error: got %b expected 0", training_error); end
    tests_run++; if (channel_locked !== 4'hF) begin tests_failed++; $display("FAIL aligned_locked: got %h expected f", channel_locked); end
    tests_run++; if (slips(0) + slips(1) + slips(2) + slips(3) != 0) begin tests_failed++; $display("FAIL aligned_slips: got %0d expected 0", slips(0) + slips(1) + slips(2) + slips(3)); end
    @(negedge clk_rxg) cmd = 1'b0;
    @(posedge clk_rxg); #1;
    tests_run++; if (training_done !== 1'b0) begin tests_failed++; $display("FAIL aligned_done_clear: got %b expected 0", training_done); end
    tests_run++; if (channel_locked !== 4'hF) begin tests_failed++; $display("FAIL aligned_locked_held: got %h expected f", channel_locked); end
  endtask

  task automatic test_rotated_ch2();
    int r[NUM_CH] = '{0, 0, 3, 0};
    int lat; bit ok;
    set_lanes(r, 4'h0);
    @(negedge clk_rxg) cmd = 1'b1;
    run_to_done(lat, ok);
    tests_run++; if (!ok || lat != 1 + 4*ROUND) begin tests_failed++; $display("FAIL rot_latency: got %0d (done=%b) expected %0d", lat, ok, 1 + 4*ROUND); end
    tests_run++; if (slips(2) != 3 || slips(0) + slips(1) + slips(3) != 0) begin tests_failed++; $display("FAIL rot_slips: got ch2=%0d others=%0d expected 3/0", slips(2), slips(0) + slips(1) + slips(3)); end
    tests_run++; if (channel_locked !== 4'hF || training_error !== 1'b0) begin tests_failed++; $display("FAIL rot_result: got locked=%h err=%b expected f/0", channel_locked, training_error); end
    @(negedge clk_rxg) cmd = 1'b0;
    @(posedge clk_rxg); #1;
  endtask

  task automatic test_stuck_ch0();
    int r[NUM_CH] = '{0, 0, 0, 0};
    int lat; bit ok;
    set_lanes(r, 4'h1);
    @(negedge clk_rxg) cmd = 1'b1;
    run_to_done(lat, ok);
    tests_run++; if (!ok || lat != 1 + 11*ROUND) begin tests_failed++; $display("FAIL stuck_latency: got %0d (done=%b) expected %0d", lat, ok, 1 + 11*ROUND); end
    tests_run++; if (slips(0) != DW) begin tests_failed++; $display("FAIL stuck_slips: got %0d expected %0d", slips(0), DW); end
    tests_run++; if (training_error !== 1'b1) begin tests_failed++; $display("FAIL stuck_error: got %b expected 1", training_error); end
    tests_run++; if (channel_locked !== 4'hE) begin tests_failed++; $display("FAIL stuck_locked: got %h expected e", channel_locked); end
    @(negedge clk_rxg) cmd = 1'b0;
    @(posedge clk_rxg); #1;
    stuck = 4'h0;
  endtask

  task automatic test_abort();
    int r[NUM_CH] = '{0, 0, 3, 0};
    int lat; bit ok; bit saw_done;
    set_lanes(r, 4'h0);
    @(negedge clk_rxg) cmd = 1'b1;
    repeat (40) @(posedge clk_rxg);
    @(negedge clk_rxg) cmd = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk_rxg); #1;
      if (training_done !== 1'b0) saw_done = 1'b1;
    end
    tests_run++; if (saw_done) begin tests_failed++; $display("FAIL abort_done: got done=1 expected 0"); end
    tests_run++; if (slips(2) != 1) begin tests_failed++; $display("FAIL abort_slips: got %0d expected 1", slips(2)); end
    r[2] = 2;
    set_lanes(r, 4'h0);
    @(negedge clk_rxg) cmd = 1'b1;
    @(posedge clk_rxg); #1;
    tests_run++; if (channel_locked !== 4'h0) begin tests_failed++; $display("FAIL restart_clear: got %h expected 0", channel_locked); end
    run_to_done(lat, ok);
    tests_run++; if (!ok || lat + 1 != 1 + 3*ROUND) begin tests_failed++; $display("FAIL restart_latency: got %0d (done=%b) expected %0d", lat + 1, ok, 1 + 3*ROUND); end
    tests_run++; if (channel_locked !== 4'hF || training_error !== 1'b0 || slips(2) != 2) begin tests_failed++; $display("FAIL restart_result: got locked=%h err=%b slips=%0d expected f/0/2", channel_locked, training_error, slips(2)); end
    @(negedge clk_rxg) cmd = 1'b0;
    @(posedge clk_rxg); #1;
  endtask

  task automatic test_reset_in_eval();
    int r[NUM_CH] = '{5, 0, 0, 0};
    int lat; bit ok;
    set_lanes(r, 4'h0);
    @(negedge clk_rxg) cmd = 1'b1;
    repeat (ROUND) @(posedge clk_rxg); #1;
    tests_run++; if (bitslip !== 4'h1) begin tests_failed++; $display("FAIL eval_pending_slip: got %h expected 1", bitslip); end
    rst_rx_n = 1'b0;
    #1;
    tests_run++; if (bitslip !== 4'h0) begin tests_failed++; $display("FAIL rst_eval_bitslip: got %h expected 0", bitslip); end
    tests_run++; if (channel_locked !== 4'h0 || training_done !== 1'b0 || training_error !== 1'b0) begin tests_failed++; $display("FAIL rst_eval_outputs: got locked=%h done=%b err=%b expected 0", channel_locked, training_done, training_error); end
    cmd = 1'b0;
    @(negedge clk_rxg) rst_rx_n = 1'b1;
    repeat (5) @(posedge clk_rxg); #1;
    tests_run++; if (slips(0) != 0 || training_done !== 1'b0) begin tests_failed++; $display("FAIL rst_eval_idle: got slips=%0d done=%b expected 0/0", slips(0), training_done); end
    set_lanes(r, 4'h0);
    @(negedge clk_rxg) cmd = 1'b1;
    run_to_done(lat, ok);
    tests_run++; if (!ok || lat != 1 + 6*ROUND || slips(0) != 5 || channel_locked !== 4'hF) begin tests_failed++; $display("FAIL rst_eval_rerun: got lat=%0d slips=%0d locked=%h expected %0d/5/f", lat, slips(0), channel_locked, 1 + 6*ROUND); end
    @(negedge clk_rxg) cmd = 1'b0;
    @(posedge clk_rxg); #1;
  endtask

  task automatic test_glitch_ch1();
    int r[NUM_CH] = '{0, 0, 0, 0};
    int lat; bit ok;
    set_lanes(r, 4'h0);
    @(negedge clk_rxg) cmd = 1'b1;
    repeat (15) @(posedge clk_rxg);
    @(negedge clk_rxg) glitch = 4'h2;
    @(negedge clk_rxg) glitch = 4'h0;
    repeat (10) @(posedge clk_rxg); #1;
    tests_run++; if (channel_locked !== 4'hD || slips(1) != 1 || training_done !== 1'b0) begin tests_failed++; $display("FAIL glitch_window: got locked=%h slips=%0d done=%b expected d/1/0", channel_locked, slips(1), training_done); end
    run_to_done(lat, ok);
    tests_run++; if (!ok || lat + 1 + ROUND != 1 + 11*ROUND) begin tests_failed++; $display("FAIL glitch_latency: got %0d (done=%b) expected %0d", lat + 1 + ROUND, ok, 1 + 11*ROUND); end
    tests_run++; if (slips(1) != DW || channel_locked !== 4'hF || training_error !== 1'b0) begin tests_failed++; $display("FAIL glitch_result: got slips=%0d locked=%h err=%b expected 10/f/0", slips(1), channel_locked, training_error); end
    @(negedge clk_rxg) cmd = 1'b0;
    @(posedge clk_rxg); #1;
  endtask

  task automatic test_random();
    int r[NUM_CH];
    logic [NUM_CH-1:0] st;
    int rounds, lat; bit ok;
    for (int it = 0; it < 5; it++) begin
      st = '0;
      for (int k = 0; k < NUM_CH; k++) r[k] = int'($urandom_range(0, DW - 1));
      if ($urandom_range(0, 1) == 1) st[$urandom_range(0, NUM_CH - 1)] = 1'b1;
      set_lanes(r, st);
      rounds = 1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (st[k] && rounds < DW + 1) rounds = DW + 1;
        if (!st[k] && rounds < r[k] + 1) rounds = r[k] + 1;
      end
      @(negedge clk_rxg) cmd = 1'b1;
      run_to_done(lat, ok);
      tests_run++; if (!ok || lat != 1 + rounds*ROUND) begin tests_failed++; $display("FAIL rand%0d_latency: got %0d (done=%b) expected %0d", it, lat, ok, 1 + rounds*ROUND); end
      tests_run++; if (channel_locked !== ~st || training_error !== (|st)) begin tests_failed++; $display("FAIL rand%0d_result: got locked=%h err=%b expected %h/%b", it, channel_locked, training_error, ~st, |st); end
      for (int k = 0; k < NUM_CH; k++) begin
        tests_run++; if (slips(k) != (st[k] ? DW : r[k])) begin tests_failed++; $display("FAIL rand%0d_slips_ch%0d: got %0d expected %0d", it, k, slips(k), st[k] ? DW : r[k]); end
      end
      @(negedge clk_rxg) cmd = 1'b0;
      @(posedge clk_rxg); #1;
      tests_run++; if (training_done !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_done_clear: got %b expected 0", it, training_done); end
    end
    stuck = '0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    stuck = '0; glitch = '0;
    test_reset();
    test_aligned();
    test_rotated_ch2();
    test_stuck_ch0();
    test_abort();
    test_reset_in_eval();
    test_glitch_ch1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sensor_training.md
SENSOR_TRAINING -- requirements
Module: sensor_training

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sensor LVDS data channels.
REQ-002 SHALL have parameter DATA_W, default 10, deserialized word width per channel.
REQ-003 SHALL have parameter TRAIN_PATTERN, default 10'h3A6, sensor training word.
REQ-004 SHALL have parameter SETTLE_CYC, default 8, wait cycles after any bitslip or start.
REQ-005 SHALL have parameter MATCH_CYC, default 16, check window length in cycles.
REQ-006 SHALL have port clk_rxg  input  1  deserialized-word clock; the only clock.
REQ-007 SHALL have port rst_rx_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port cmd_start_training  input  1  level request from the camera controller, held high until training_done is seen.
REQ-009 SHALL have port rx_data  input  NUM_CH*DATA_W  deserialized words; channel k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port bitslip  output  NUM_CH  one-cycle bitslip pulse per channel to the deserializers.
REQ-011 SHALL have port channel_locked  output  NUM_CH  per-channel alignment achieved in the current run.
REQ-012 SHALL have port training_done  output  1  run finished, pass or fail; consumed as a rising edge.
REQ-013 SHALL have port training_error  output  1  run failed; valid while training_done=1.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CHECK, EVAL, DONE.
REQ-015 IDLE: on cmd_start_training=1, clear channel_locked, all slip counters and done/error, then go to SETTLE.
REQ-016 SETTLE: count SETTLE_CYC cycles, then go to CHECK; rx_data is ignored.
REQ-017 CHECK: for MATCH_CYC cycles, set a sticky per-channel mismatch flag when the channel word != TRAIN_PATTERN; go to EVAL after the last window cycle.
REQ-018 EVAL (one cycle): a channel with no mismatch SHALL set channel_locked; an unlocked mismatching channel with slip_cnt < DATA_W SHALL pulse bitslip for exactly this cycle and increment slip_cnt.
REQ-019 EVAL: a mismatching unlocked channel with slip_cnt == DATA_W SHALL set training_error.
REQ-020 EVAL exit: if all channels are locked or training_error is set, go to DONE; otherwise clear the mismatch flags and go to SETTLE.
REQ-021 Locked channels SHALL never receive bitslip again in the same run and SHALL be excluded from mismatch evaluation.
REQ-022 DONE: training_done=1 and training_error held; return to IDLE when cmd_start_training=0, clearing training_done; channel_locked is held.
REQ-023 If cmd_start_training drops in SETTLE, CHECK or EVAL, the run SHALL abort to IDLE with no bitslip pulse issued in that cycle and training_done staying 0.
REQ-024 slip_cnt SHALL be ceil(log2(DATA_W+1)) bits wide per channel and SHALL never wrap.
REQ-025 Minimum pass latency from start to training_done with zero slips SHALL be 1+SETTLE_CYC+MATCH_CYC+1 cycles.

Reset
REQ-026 While rst_rx_n=0, the block SHALL be in IDLE with bitslip=0, channel_locked=0, training_done=0, training_error=0, and all counters and flags at 0.
REQ-027 Reset assertion mid-run SHALL take effect immediately and asynchronously; deassertion SHALL be synchronous to clk_rxg, after which the block stays in IDLE until cmd_start_training=1.

Structure
REQ-028 The FSM state encoding and the default TRAIN_PATTERN constant SHALL reside in package sensor_training_pkg.
REQ-029 Per-channel logic (mismatch flag, slip_cnt, lock, bitslip pulse) SHALL be sub-module training_lane, instantiated NUM_CH times; the top SHALL hold the FSM and the window and settle counters.

Verification
REQ-030 All 4 channels send 10'h3A6 from start: training_done rises 26 cycles after cmd_start_training, with error=0, locked=4'hF, and no bitslip.
REQ-031 Channel 2 sends the pattern rotated by 3 bits and the model rotates on bitslip: exactly 3 bitslip[2] pulses occur, locked=4'hF, and error=0.
REQ-032 Channel 0 sends constant 10'h000: 10 bitslip[0] pulses occur, then training_done=1, error=1, and locked=4'hE.
REQ-033 cmd_start_training drops during the 2nd CHECK window: FSM returns to IDLE, training_done stays 0, and a restart trains cleanly.
REQ-034 rst_rx_n asserted during EVAL with a pending slip: bitslip is 0 in the same cycle and all outputs are 0.
REQ-035 A single-cycle glitch word on channel 1 within the window costs that channel one slip and does not lock it in that window.
